// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control and serial-stream signals of the pattern transmitter.
// gap_len is present only when SEQ_PATTERN_GEN_GAP_EN is defined.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [4:0]       pat_len;
  logic [CNT_W-1:0] repeat_cnt;
`ifdef SEQ_PATTERN_GEN_GAP_EN
  logic [3:0]       gap_len;
`endif
  logic             output_bit;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  modport master (
    output start, abort, pattern, pat_len, repeat_cnt,
`ifdef SEQ_PATTERN_GEN_GAP_EN
    output gap_len,
`endif
    input  output_bit, bit_valid, frame_start, busy, done
  );
  modport slave (
    input  start, abort, pattern, pat_len, repeat_cnt,
`ifdef SEQ_PATTERN_GEN_GAP_EN
    input  gap_len,
`endif
    output output_bit, bit_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern transmitter with repeat, abort and busy/done status.
// Define SEQ_PATTERN_GEN_GAP_EN to insert gap_len idle cycles between consecutive frames.
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input logic              clock,
  input logic              reset,
  seq_pattern_gen_if.slave bus
);
`ifdef SEQ_PATTERN_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, DONE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif
  state_t           state, state_n;
  logic [PAT_W-1:0] pat, pat_n, in_sh, nxt_sh, top_sh;
  logic [4:0]       len, len_n, idx, idx_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [4:0]       out, out_n;
  logic             legal, reload;
`ifdef SEQ_PATTERN_GEN_GAP_EN
  logic [3:0]       glen, glen_n, gcnt, gcnt_n;
`endif
  assign legal  = bus.pat_len != 5'd0 && bus.pat_len <= 5'(PAT_W) && bus.repeat_cnt != '0;
  assign in_sh  = bus.pattern >> (bus.pat_len - 5'd1);
  assign nxt_sh = pat >> (idx - 5'd1);
  assign top_sh = pat >> (len - 5'd1);
  // out packs {output_bit, bit_valid, frame_start, busy, done}, all registered
  assign {bus.output_bit, bus.bit_valid, bus.frame_start, bus.busy, bus.done} = out;
  always_comb begin
    state_n = state;
    pat_n   = pat;
    len_n   = len;
    idx_n   = idx;
    rem_n   = rem;
    out_n   = '0;
    reload  = 1'b0;
`ifdef SEQ_PATTERN_GEN_GAP_EN
    glen_n  = glen;
    gcnt_n  = gcnt;
`endif
    case (state)
      IDLE: if (bus.start && legal) begin
        state_n = SEND;
        pat_n   = bus.pattern;
        len_n   = bus.pat_len;
        idx_n   = bus.pat_len - 5'd1;
        rem_n   = bus.repeat_cnt;
        out_n   = {in_sh[0], 4'b1110};
`ifdef SEQ_PATTERN_GEN_GAP_EN
        glen_n  = bus.gap_len;
`endif
      end else if (bus.start) begin
        state_n = DONE;
        out_n   = 5'b00001;
      end
      SEND: if (idx != 5'd0) begin
        idx_n = idx - 5'd1;
        out_n = {nxt_sh[0], 4'b1010};
      end else if (rem > CNT_W'(1)) begin
        rem_n = rem - CNT_W'(1);
`ifdef SEQ_PATTERN_GEN_GAP_EN
        if (glen != 4'd0) begin
          state_n = GAP;
          gcnt_n  = glen;
          out_n   = 5'b00010;
        end else reload = 1'b1;
`else
        reload = 1'b1;
`endif
      end else begin
        state_n = DONE;
        out_n   = 5'b00001;
      end
`ifdef SEQ_PATTERN_GEN_GAP_EN
      GAP: if (gcnt > 4'd1) begin
        gcnt_n = gcnt - 4'd1;
        out_n  = 5'b00010;
      end else begin
        state_n = SEND;
        reload  = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (reload) begin
      idx_n = len - 5'd1;
      out_n = {top_sh[0], 4'b1110};
    end
    // abort outranks start and end-of-frame, and suppresses the done pulse
    if (bus.abort) begin
      state_n = IDLE;
      out_n   = '0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pat   <= '0;
      len   <= '0;
      idx   <= '0;
      rem   <= '0;
      out   <= '0;
`ifdef SEQ_PATTERN_GEN_GAP_EN
      glen  <= '0;
      gcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      pat   <= pat_n;
      len   <= len_n;
      idx   <= idx_n;
      rem   <= rem_n;
      out   <= out_n;
`ifdef SEQ_PATTERN_GEN_GAP_EN
      glen  <= glen_n;
      gcnt  <= gcnt_n;
`endif
    end
endmodule
